// File: rtl/lfsr_prbs_checker_pkg.sv
// Shared definitions for the XNOR-LFSR PRBS checker: FSM encodings and output widths.
package lfsr_prbs_checker_pkg;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int WORD_W = 32;
    localparam int ERR_W  = 16;

endpackage

// File: rtl/lfsr_prbs_checker_predictor.sv
// History shift register and next-bit predictor for an XNOR LFSR x^N + x^T + 1.
module lfsr_prbs_checker_predictor #(
    parameter int N = 10,
    parameter int T = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic shift_en,
    input  logic din,
    output logic exp_bit
);

    logic [N-1:0] hist_q;
    logic [N-1:0] hist_d;

    // Received bits (never the prediction) enter the history so the predictor re-seeds itself.
    always_comb begin
        hist_d = hist_q;
        if (shift_en) begin
            hist_d = {hist_q[N-2:0], din};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign exp_bit = ~(hist_q[N-1] ^ hist_q[T-1]);

endmodule

// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising PRBS checker: seeds, verifies and locks to an XNOR LFSR stream, counts
// bit errors while locked and packs locked bits MSB-first into 32-bit words.
module lfsr_prbs_checker
    import lfsr_prbs_checker_pkg::*;
#(
    parameter int N        = 10,
    parameter int T        = 7,
    parameter int LOCK_CNT = 16,
    parameter int UNLOCK_E = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              din_valid,
    input  logic              din,
    input  logic              err_clr,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [WORD_W-1:0] word,
    output logic              word_valid,
    output logic [1:0]        state
);

    localparam int SEED_W = (N > 1) ? $clog2(N) : 1;
    localparam int GOOD_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam int WERR_W = (UNLOCK_E > 1) ? $clog2(UNLOCK_E) : 1;
    localparam int IDX_W  = $clog2(WORD_W);

    localparam logic [SEED_W-1:0] SEED_LAST   = SEED_W'(N - 1);
    localparam logic [GOOD_W-1:0] LOCK_LAST   = GOOD_W'(LOCK_CNT - 1);
    localparam logic [WERR_W-1:0] UNLOCK_LAST = WERR_W'(UNLOCK_E - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(WORD_W - 1);

    state_t              state_q, state_d;
    logic [SEED_W-1:0]   seed_cnt_q, seed_cnt_d;
    logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;
    logic [WERR_W-1:0]   win_err_q, win_err_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                word_valid_q, word_valid_d;
    logic                err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;

    logic exp_bit;
    logic mismatch;
    logic seed_done;
    logic lock_hit;
    logic unlock_hit;
    logic err_hit;

    lfsr_prbs_checker_predictor #(
        .N (N),
        .T (T)
    ) u_pred (
        .clk      (clk),
        .reset    (reset),
        .shift_en (din_valid),
        .din      (din),
        .exp_bit  (exp_bit)
    );

    assign mismatch   = (din != exp_bit);
    assign seed_done  = (seed_cnt_q == SEED_LAST);
    assign lock_hit   = !mismatch && (good_cnt_q == LOCK_LAST);
    assign unlock_hit = mismatch && (win_err_q == UNLOCK_LAST);
    assign err_hit    = din_valid && (state_q == ST_LOCKED) && mismatch;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (din_valid) begin
            unique case (state_q)
                ST_SEED:   if (seed_done) state_d = ST_VERIFY;
                ST_VERIFY: begin
                    if (mismatch)      state_d = ST_SEED;
                    else if (lock_hit) state_d = ST_LOCKED;
                end
                ST_LOCKED: if (unlock_hit) state_d = ST_SEED;
                default:   state_d = ST_SEED;
            endcase
        end
    end

    always_comb begin
        seed_cnt_d   = seed_cnt_q;
        good_cnt_d   = good_cnt_q;
        win_err_d    = win_err_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        err_pulse_d  = 1'b0;
        if (din_valid) begin
            unique case (state_q)
                ST_SEED: begin
                    seed_cnt_d = seed_done ? '0 : seed_cnt_q + 1'b1;
                    good_cnt_d = '0;
                end
                ST_VERIFY: begin
                    good_cnt_d = (mismatch || lock_hit) ? '0 : good_cnt_q + 1'b1;
                    seed_cnt_d = '0;
                    // Word index and window start fresh on every entry to LOCKED.
                    idx_d      = '0;
                    win_err_d  = '0;
                    acc_d      = '0;
                end
                ST_LOCKED: begin
                    acc_d       = {acc_q[WORD_W-2:0], din};
                    idx_d       = idx_q + 1'b1;
                    err_pulse_d = mismatch;
                    if (idx_q == IDX_LAST) begin
                        word_d       = acc_d;
                        word_valid_d = 1'b1;
                        win_err_d    = '0;
                    end else if (mismatch) begin
                        win_err_d = win_err_q + 1'b1;
                    end
                    if (unlock_hit) begin
                        seed_cnt_d = '0;
                        win_err_d  = '0;
                        idx_d      = '0;
                        acc_d      = '0;
                    end
                end
                default: seed_cnt_d = '0;
            endcase
        end
    end

    // A clear coincident with a counted error leaves that one error visible.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = err_hit ? ERR_W'(1) : '0;
        end else if (err_hit && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seed_cnt_q   <= '0;
            good_cnt_q   <= '0;
            win_err_q    <= '0;
            idx_q        <= '0;
            acc_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            seed_cnt_q   <= seed_cnt_d;
            good_cnt_q   <= good_cnt_d;
            win_err_q    <= win_err_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            err_pulse_q  <= err_pulse_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign locked     = (state_q == ST_LOCKED);
    assign err_pulse  = err_pulse_q;
    assign err_cnt    = err_cnt_q;
    assign word       = word_q;
    assign word_valid = word_valid_q;
    assign state      = state_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Directed bench for lfsr_prbs_checker: lock timing, error counting, unlock/relock,
// err_clr and saturation, async reset and half-rate input.
module tb_lfsr_prbs_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        din_valid = 1'b0;
    logic        din = 1'b0;
    logic        err_clr = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_cnt;
    logic [31:0] word;
    logic        word_valid;
    logic [1:0]  state;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [9:0] gen_q;

    lfsr_prbs_checker dut (
        .clk        (clk),
        .reset      (reset),
        .din_valid  (din_valid),
        .din        (din),
        .err_clr    (err_clr),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_cnt    (err_cnt),
        .word       (word),
        .word_valid (word_valid),
        .state      (state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference generator: same x^10 + x^7 + 1 XNOR recurrence as the transmit chain.
    task automatic gen_bit(output logic b);
        b = ~(gen_q[9] ^ gen_q[6]);
        gen_q = {gen_q[8:0], b};
    endtask

    task automatic send(input logic b);
        din = b;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        din_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_clean(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            gen_bit(b);
            send(b);
        end
    endtask

    task automatic send_flip();
        logic b;
        gen_bit(b);
        send(~b);
    endtask

    task automatic do_reset();
        din_valid = 1'b0;
        din = 1'b0;
        err_clr = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic lock_up(input logic [9:0] seed);
        do_reset();
        gen_q = seed;
        send_clean(26);
        chk_cnt++;
        if (locked !== 1'b1) $display("FAIL lock_up: locked=%0b expected 1", locked);
        else pass_cnt++;
    endtask

    task automatic test_clean_lock();
        logic [31:0] exp_word;
        logic b;
        logic seen_wv;
        do_reset();
        chk_cnt++;
        if ({state, locked, err_pulse, word_valid} !== 5'b0 || err_cnt !== 16'h0 || word !== 32'h0)
            $display("FAIL reset_state: state=%0d locked=%0b err_cnt=%h word=%h expected all 0",
                     state, locked, err_cnt, word);
        else pass_cnt++;
        gen_q = 10'h2A5;
        send_clean(9);
        chk_cnt++;
        if (state !== 2'd0) $display("FAIL seed_9bits: state=%0d expected 0", state);
        else pass_cnt++;
        send_clean(1);
        chk_cnt++;
        if (state !== 2'd1) $display("FAIL seed_10bits: state=%0d expected 1", state);
        else pass_cnt++;
        send_clean(15);
        chk_cnt++;
        if (locked !== 1'b0 || state !== 2'd1) $display("FAIL verify_25bits: locked=%0b state=%0d expected 0/1", locked, state);
        else pass_cnt++;
        send_clean(1);
        chk_cnt++;
        if (locked !== 1'b1 || state !== 2'd2) $display("FAIL lock_26bits: locked=%0b state=%0d expected 1/2", locked, state);
        else pass_cnt++;
        exp_word = '0;
        seen_wv = 1'b0;
        for (int i = 0; i < 31; i++) begin
            gen_bit(b);
            exp_word = {exp_word[30:0], b};
            send(b);
            if (word_valid === 1'b1) seen_wv = 1'b1;
        end
        chk_cnt++;
        if (seen_wv !== 1'b0) $display("FAIL early_word_valid: seen=%0b expected 0", seen_wv);
        else pass_cnt++;
        gen_bit(b);
        exp_word = {exp_word[30:0], b};
        send(b);
        chk_cnt++;
        if (word_valid !== 1'b1 || word !== exp_word)
            $display("FAIL first_word: word_valid=%0b word=%h expected 1/%h", word_valid, word, exp_word);
        else pass_cnt++;
        chk_cnt++;
        if (err_cnt !== 16'h0) $display("FAIL clean_err_cnt: err_cnt=%h expected 0", err_cnt);
        else pass_cnt++;
        send_clean(1);
        chk_cnt++;
        if (word_valid !== 1'b0 || word !== exp_word)
            $display("FAIL word_hold: word_valid=%0b word=%h expected 0/%h", word_valid, word, exp_word);
        else pass_cnt++;
        $display("test_clean_lock: locked=%0b word=%h", locked, word);
    endtask

    task automatic test_reset();
        #3;
        reset = 1'b0;
        #1;
        chk_cnt++;
        if ({state, locked, err_pulse, word_valid} !== 5'b0 || err_cnt !== 16'h0 || word !== 32'h0)
            $display("FAIL async_reset: state=%0d locked=%0b word=%h expected all 0", state, locked, word);
        else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++;
        if (state !== 2'd0 || word !== 32'h0) $display("FAIL reset_hold: state=%0d word=%h expected 0/0", state, word);
        else pass_cnt++;
        reset = 1'b1;
        $display("test_reset: state=%0d", state);
    endtask

    task automatic test_single_error();
        lock_up(10'h155);
        send_clean(3);
        send_flip();
        chk_cnt++;
        if (err_pulse !== 1'b1 || err_cnt !== 16'd1 || locked !== 1'b1)
            $display("FAIL single_err: pulse=%0b err_cnt=%0d locked=%0b expected 1/1/1", err_pulse, err_cnt, locked);
        else pass_cnt++;
        send_clean(1);
        chk_cnt++;
        if (err_pulse !== 1'b0 || err_cnt !== 16'd1)
            $display("FAIL single_err_pulse_drop: pulse=%0b err_cnt=%0d expected 0/1", err_pulse, err_cnt);
        else pass_cnt++;
        // The corrupted bit re-enters the predictor at taps 7 and 10 bits later.
        send_clean(6);
        chk_cnt++;
        if (err_pulse !== 1'b1 || err_cnt !== 16'd2)
            $display("FAIL echo_tap7: pulse=%0b err_cnt=%0d expected 1/2", err_pulse, err_cnt);
        else pass_cnt++;
        send_clean(3);
        chk_cnt++;
        if (err_cnt !== 16'd3 || locked !== 1'b1)
            $display("FAIL echo_tap10: err_cnt=%0d locked=%0b expected 3/1", err_cnt, locked);
        else pass_cnt++;
        send_clean(25);
        chk_cnt++;
        if (err_cnt !== 16'd3 || locked !== 1'b1)
            $display("FAIL after_window: err_cnt=%0d locked=%0b expected 3/1", err_cnt, locked);
        else pass_cnt++;
        $display("test_single_error: err_cnt=%0d", err_cnt);
    endtask

    task automatic test_unlock_relock();
        lock_up(10'h0F0);
        send_clean(5);
        repeat (3) send_flip();
        chk_cnt++;
        if (err_cnt !== 16'd3 || locked !== 1'b1)
            $display("FAIL three_errs: err_cnt=%0d locked=%0b expected 3/1", err_cnt, locked);
        else pass_cnt++;
        send_flip();
        chk_cnt++;
        if (locked !== 1'b0 || state !== 2'd0 || err_cnt !== 16'd4 || err_pulse !== 1'b1)
            $display("FAIL unlock: locked=%0b state=%0d err_cnt=%0d pulse=%0b expected 0/0/4/1",
                     locked, state, err_cnt, err_pulse);
        else pass_cnt++;
        send_clean(25);
        chk_cnt++;
        if (locked !== 1'b0) $display("FAIL relock_early: locked=%0b expected 0", locked);
        else pass_cnt++;
        send_clean(1);
        chk_cnt++;
        if (locked !== 1'b1 || err_cnt !== 16'd4)
            $display("FAIL relock: locked=%0b err_cnt=%0d expected 1/4", locked, err_cnt);
        else pass_cnt++;
        $display("test_unlock_relock: err_cnt=%0d", err_cnt);
    endtask

    task automatic test_err_clr();
        lock_up(10'h2A5);
        send_clean(2);
        send_flip();
        send_clean(2);
        err_clr = 1'b1;
        send_flip();
        err_clr = 1'b0;
        chk_cnt++;
        if (err_cnt !== 16'd1 || err_pulse !== 1'b1)
            $display("FAIL clr_with_err: err_cnt=%0d pulse=%0b expected 1/1", err_cnt, err_pulse);
        else pass_cnt++;
        err_clr = 1'b1;
        send_clean(1);
        err_clr = 1'b0;
        chk_cnt++;
        if (err_cnt !== 16'd0) $display("FAIL clr_plain: err_cnt=%0d expected 0", err_cnt);
        else pass_cnt++;
        lock_up(10'h155);
        force dut.err_cnt_q = 16'hFFFF;
        #1;
        release dut.err_cnt_q;
        send_clean(1);
        chk_cnt++;
        if (err_cnt !== 16'hFFFF) $display("FAIL sat_preload: err_cnt=%h expected ffff", err_cnt);
        else pass_cnt++;
        send_flip();
        chk_cnt++;
        if (err_cnt !== 16'hFFFF || err_pulse !== 1'b1)
            $display("FAIL saturate: err_cnt=%h pulse=%0b expected ffff/1", err_cnt, err_pulse);
        else pass_cnt++;
        $display("test_err_clr: err_cnt=%h", err_cnt);
    endtask

    task automatic test_half_rate();
        logic [31:0] exp_word;
        logic b;
        do_reset();
        gen_q = 10'h13C;
        for (int i = 1; i <= 26; i++) begin
            gen_bit(b);
            send(b);
            if (i == 9) begin
                chk_cnt++;
                if (state !== 2'd0) $display("FAIL half_seed_9: state=%0d expected 0", state);
                else pass_cnt++;
            end
            if (i == 25) begin
                chk_cnt++;
                if (locked !== 1'b0) $display("FAIL half_verify_25: locked=%0b expected 0", locked);
                else pass_cnt++;
            end
            idle();
            if (i == 10) begin
                chk_cnt++;
                if (state !== 2'd1) $display("FAIL half_seed_10: state=%0d expected 1", state);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (locked !== 1'b1) $display("FAIL half_lock: locked=%0b expected 1", locked);
        else pass_cnt++;
        exp_word = '0;
        for (int i = 1; i <= 32; i++) begin
            gen_bit(b);
            exp_word = {exp_word[30:0], b};
            send(b);
            if (i == 32) begin
                chk_cnt++;
                if (word_valid !== 1'b1 || word !== exp_word)
                    $display("FAIL half_word: word_valid=%0b word=%h expected 1/%h", word_valid, word, exp_word);
                else pass_cnt++;
            end
            idle();
        end
        chk_cnt++;
        if (word_valid !== 1'b0 || word !== exp_word || err_cnt !== 16'h0)
            $display("FAIL half_idle_hold: word_valid=%0b word=%h err_cnt=%0d expected 0/%h/0",
                     word_valid, word, err_cnt, exp_word);
        else pass_cnt++;
        $display("test_half_rate: word=%h", word);
    endtask

    initial begin
        test_clean_lock();
        test_reset();
        test_single_error();
        test_unlock_relock();
        test_err_clr();
        test_half_rate();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
